// File: rtl/instr_fetch_unit_if.sv
// Fetch-to-decode bundle: instruction handshake plus redirect request.
// master = fetch stage, slave = decode stage.
interface instr_fetch_unit_if #(
    parameter int BITS_DATA = 32,
    parameter int BITS_ADDR = 7
);
    logic [BITS_DATA-1:0] instr;
    logic [BITS_ADDR-1:0] instr_pc;
    logic                 instr_valid;
    logic                 instr_ready;
    logic                 redirect;
    logic                 redirect_sel;
    logic [BITS_ADDR-1:0] branch_target;
    logic [BITS_ADDR-1:0] jump_target;

    modport master (
        output instr, instr_pc, instr_valid,
        input  instr_ready, redirect, redirect_sel,
        input  branch_target, jump_target
    );

    modport slave (
        input  instr, instr_pc, instr_valid,
        output instr_ready, redirect, redirect_sel,
        output branch_target, jump_target
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, latches the word from async imem and
// hands it to decode over valid/ready, with branch/jump redirects.
module instr_fetch_unit #(
    parameter int                BITS_DATA = 32,
    parameter int                BITS_ADDR = 7,
    parameter logic [BITS_ADDR-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [BITS_ADDR-1:0] imem_addr,
    input  logic [BITS_DATA-1:0] imem_rd,
    output logic                 fetch_err,
    output logic                 busy,
    instr_fetch_unit_if.master   fif
);
    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        VALID,
        ERROR
    } state_t;

    state_t               state;
    state_t               state_n;
    logic [BITS_ADDR-1:0] pc;
    logic [BITS_ADDR-1:0] seq_pc;
    logic [BITS_ADDR-1:0] target;
    logic                 pc_ld;
    logic [BITS_DATA-1:0] instr_q;
    logic [BITS_ADDR-1:0] instr_pc_q;

    // Sequential PC wraps naturally in BITS_ADDR bits.
    assign seq_pc = pc + BITS_ADDR'(4);

    always_comb begin
        target = seq_pc;
        if (fif.redirect) begin
            target = fif.redirect_sel ? fif.jump_target
                                      : fif.branch_target;
        end
    end

    always_comb begin
        state_n = state;
        pc_ld   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_n = FETCH;
            end
            FETCH: begin
                state_n = VALID;
            end
            VALID: begin
                if (fif.instr_ready) begin
                    if (target[1:0] != 2'b00) begin
                        state_n = ERROR;
                    end else begin
                        state_n = FETCH;
                        pc_ld   = 1'b1;
                    end
                end
            end
            ERROR: begin
                state_n = ERROR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state <= state_n;
            if (state == FETCH) begin
                instr_q    <= imem_rd;
                instr_pc_q <= pc;
            end
            if (pc_ld) pc <= target;
        end
    end

    assign imem_addr       = pc;
    assign fif.instr       = instr_q;
    assign fif.instr_pc    = instr_pc_q;
    assign fif.instr_valid = (state == VALID);
    assign fetch_err       = (state == ERROR);
    assign busy            = (state != IDLE);
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage that sits directly upstream of the instruction memory. It owns the program counter and drives the memory's byte address. It captures the 32-bit big-endian word the memory returns into an instruction register, then presents that instruction to decode through a valid/ready handshake. It applies sequential (PC+4), branch or jump redirects and flags misaligned targets.

Parameters:
BITS_DATA, 32, instruction width; fixed at 32 (four bytes per word).
BITS_ADDR, 7, byte-address width; matches the instruction memory address bus.
RESET_PC, 0, PC value after reset; must be a multiple of 4.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  leave IDLE and begin fetching; sampled only in IDLE.
imem_addr  output  BITS_ADDR  byte address to the instruction memory; equals pc.
imem_rd  input  BITS_DATA  combinational read data from the instruction memory.
instr  output  BITS_DATA  instruction register contents.
instr_pc  output  BITS_ADDR  address instr was fetched from.
instr_valid  output  1  instr/instr_pc are valid for decode.
instr_ready  input  1  decode accepts instr this cycle.
redirect  input  1  use target instead of PC+4 at the handshake.
redirect_sel  input  1  0 = branch_target, 1 = jump_target.
branch_target  input  BITS_ADDR  branch byte address.
jump_target  input  BITS_ADDR  jump byte address.
fetch_err  output  1  sticky misaligned-target error.
busy  output  1  high in any state other than IDLE.

Behaviour:
- States are IDLE, FETCH, VALID and ERROR. Reset state is IDLE.
- Reset values: pc = RESET_PC, instr = 0, instr_pc = 0, instr_valid = 0, fetch_err = 0, busy = 0.
- rst asserted in any state, including mid-handshake: at the next edge all registers return to their reset values and the state returns to IDLE. rst takes priority over every other input.
- imem_addr = pc at all times (combinational). The memory is asynchronous, so imem_rd is sampled in the same cycle it is addressed.
- IDLE: instr_valid = 0. If start = 1 → FETCH.
- FETCH: lasts one cycle. At the edge: instr ← imem_rd, instr_pc ← pc, → VALID.
  - Latency: instr_valid rises 1 cycle after entering FETCH.
  - redirect is ignored in FETCH.
- VALID: instr_valid = 1. instr and instr_pc stay stable while instr_ready = 0 (unlimited backpressure).
  - When instr_ready = 1, the handshake completes at the edge:
    - next = redirect ? (redirect_sel ? jump_target : branch_target) : pc + 4.
    - pc + 4 is computed in BITS_ADDR bits and wraps modulo 2^BITS_ADDR (124 + 4 → 0).
    - If next[1:0] != 0 → ERROR; pc is not updated and instr_valid falls.
    - Otherwise pc ← next and the state → FETCH; instr_valid falls for exactly 1 cycle.
  - redirect and redirect_sel are sampled only on the handshake edge.
  - Throughput: one instruction per 2 cycles when instr_ready is held high.
- ERROR: fetch_err = 1, instr_valid = 0, pc frozen. Only rst exits this state.
- Alignment invariant: pc is always a multiple of 4. The highest pc is therefore 2^BITS_ADDR − 4, so pc+3 never exceeds the top of the memory array.
- busy = (state != IDLE).
- start while not in IDLE is ignored.

Test Plan:
- Sequential fetch: memory words at 0x00/0x04/0x08 = 0x20080005/0x2009000A/0x01095020; rst, then start, instr_ready = 1 → instr sequence 0x20080005 (instr_pc 0), 0x2009000A (4), 0x01095020 (8), each with instr_valid high every other cycle.
- Backpressure: hold instr_ready = 0 for 3 cycles in VALID at pc 4 → instr = 0x2009000A, instr_pc = 4 and instr_valid = 1 stay constant; imem_addr stays 4; on release, the next fetch is at 8.
- Redirects: at the handshake at pc 8, redirect = 1, redirect_sel = 0, branch_target = 0x40 → next instr_pc = 0x40. Repeat with redirect_sel = 1, jump_target = 0x10 → instr_pc = 0x10. Also drive redirect = 1 during FETCH → no effect.
- Wrap-around: RESET_PC = 0x7C, sequential handshake → next instr_pc = 0x00; instr matches the memory word at 0x00.
- Misaligned target: redirect = 1, branch_target = 0x06 → fetch_err = 1, instr_valid = 0, imem_addr frozen, start ignored. Then rst → fetch_err = 0, pc = RESET_PC, state IDLE.
- Reset mid-operation: assert rst in the cycle the handshake would complete (VALID, instr_ready = 1, redirect = 1) → next cycle instr_valid = 0, instr = 0, pc = RESET_PC, busy = 0, and the redirect target is not applied.
